// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// helpers that derive the digit count and digit-counter width.
package adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // A zero DIGIT is rejected at elaboration; guard the division so that check can fire.
  function automatic int calc_ndig(input int width, input int digit);
    return (digit < 1) ? 1 : width / digit;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_serial_adder_fa_n.sv
// N-bit combinational ripple-carry adder built from a chain of 1-bit
// full-adder cells.
module fa_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple cell reused over
// WIDTH/DIGIT clocks, with a start/busy/done handshake and registered results.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_w(NDIG);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] bx_reg;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] bx_shift;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [DIGIT-1:0] s_dig;
  logic             c_dig;
  logic             last;
  logic             accept;
  logic             ovf_next;

  assign accept   = start && (state == IDLE || state == DONE);
  assign last     = (cnt == CW'(NDIG - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // On the last digit the operand registers hold only the top digit, so its MSB is the sign bit.
  assign ovf_next = (a_reg[DIGIT-1] == bx_reg[DIGIT-1]) && (s_dig[DIGIT-1] != a_reg[DIGIT-1]);

  fa_n #(.N(DIGIT)) u_cell (
    .a   (a_reg[DIGIT-1:0]),
    .b   (bx_reg[DIGIT-1:0]),
    .cin (carry),
    .s   (s_dig),
    .cout(c_dig)
  );

  // Operands shift right so the active digit always sits in the low bits;
  // result digits enter from the top so the LSB digit ends up lowest.
  if (NDIG > 1) begin : g_multi
    logic [WIDTH-DIGIT-1:0] acc;

    assign a_shift  = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
    assign bx_shift = {{DIGIT{1'b0}}, bx_reg[WIDTH-1:DIGIT]};
    assign acc_next = {s_dig, acc};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
      end else if (state == RUN) begin
        acc <= acc_next[WIDTH-1:DIGIT];
      end
    end
  end else begin : g_single
    assign a_shift  = a_reg;
    assign bx_shift = bx_reg;
    assign acc_next = s_dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      bx_reg <= '0;
      s      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= RUN;
            a_reg  <= a;
            bx_reg <= sub ? ~b : b;
            carry  <= sub ? ~cin : cin;
            cnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry  <= c_dig;
          a_reg  <= a_shift;
          bx_reg <= bx_shift;
          if (last) begin
            state <= DONE;
            s     <= acc_next;
            cout  <= c_dig;
            ovf   <= ovf_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder: a 16/4 instance for
// arithmetic and handshake cases plus a 4/4 instance for the single-digit case.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic        sub   = 1'b0;
  logic        cin   = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] s;

  logic        start2 = 1'b0;
  logic        sub2   = 1'b0;
  logic        cin2   = 1'b0;
  logic [3:0]  a2     = '0;
  logic [3:0]  b2     = '0;
  logic        busy2, done2, cout2, ovf2;
  logic [3:0]  s2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(4)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic subv, input logic cinv);
    a     = av;
    b     = bv;
    sub   = subv;
    cin   = cinv;
    start = 1'b1;
  endtask

  // One full operation on the 16/4 instance, called at a negedge; optionally
  // pulses start and scrambles inputs mid-operation.
  task automatic runOp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic subv, input logic cinv,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input bit disturb);
    applyStimulus(av, bv, subv, cinv);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_nodone"}, 32'(done), 32'd0);
      if (disturb && k == 1) begin
        start = 1'b1;
        a     = ~av;
        b     = ~bv;
        sub   = ~subv;
        cin   = ~cinv;
      end
      if (disturb && k == 2) start = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
    checkOutput({tag, "_s"}, 32'(s), 32'(es));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(ec));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    // Reset state, observed while reset is still asserted
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_s", 32'(s), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    runOp("uwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    runOp("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    runOp("sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    runOp("borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);

    // Start pulse and input changes during busy must be ignored
    @(negedge clk);
    runOp("ignore", 16'h0100, 16'h0011, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("ignore_no_extra_done", 32'(done), 32'd0);
      checkOutput("ignore_idle", 32'(busy), 32'd0);
      checkOutput("ignore_s_hold", 32'(s), 32'h0111);
    end

    // Start held high: three back-to-back operations, period 5
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      checkOutput("b2b_done", 32'(done), (c % 5 == 0) ? 32'd1 : 32'd0);
      checkOutput("b2b_busy", 32'(busy), (c % 5 == 0) ? 32'd0 : 32'd1);
      if (c == 1) begin
        a = 16'h0010;
        b = 16'h0020;
      end
      if (c == 6) begin
        a = 16'h0100;
        b = 16'h0200;
      end
      if (c == 5)  checkOutput("b2b_s1", 32'(s), 32'h0003);
      if (c >= 6 && c <= 9) checkOutput("b2b_s_hold", 32'(s), 32'h0003);
      if (c == 10) checkOutput("b2b_s2", 32'(s), 32'h0030);
      if (c == 15) begin
        checkOutput("b2b_s3", 32'(s), 32'h0300);
        start = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("b2b_stop", 32'(busy), 32'd0);

    // Asynchronous reset after two digits have been processed
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_s", 32'(s), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("midrst_no_done", 32'(done), 32'd0);
      checkOutput("midrst_idle", 32'(busy), 32'd0);
    end
    runOp("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

    // Single-digit configuration: Done on the cycle after Start
    @(negedge clk);
    a2 = 4'd4; b2 = 4'd5; sub2 = 1'b0; cin2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("n1_busy", 32'(busy2), 32'd1);
    checkOutput("n1_nodone", 32'(done2), 32'd0);
    @(negedge clk);
    checkOutput("n1_done", 32'(done2), 32'd1);
    checkOutput("n1_busy_low", 32'(busy2), 32'd0);
    checkOutput("n1_s", 32'(s2), 32'h9);
    checkOutput("n1_cout", 32'(cout2), 32'd0);
    checkOutput("n1_ovf", 32'(ovf2), 32'd1);
    @(negedge clk);
    a2 = 4'd4; b2 = 4'd5; sub2 = 1'b1; cin2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    checkOutput("n1sub_done", 32'(done2), 32'd1);
    checkOutput("n1sub_s", 32'(s2), 32'hF);
    checkOutput("n1sub_cout", 32'(cout2), 32'd0);
    checkOutput("n1sub_ovf", 32'(ovf2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

- Parametrised, multi-cycle adder/subtractor: adds two WIDTH-bit operands one DIGIT-bit digit per clock, through a single DIGIT-bit ripple-carry cell and a registered carry.
- Start/Busy/Done handshake; result, carry-out and signed-overflow outputs are registered.
- Serves as the area-reduced arithmetic unit for the datapath wherever a full-width ripple adder is too large and multi-cycle latency is acceptable.

## Interface
- WIDTH, 16: operand/result width; must be a positive multiple of DIGIT.
- DIGIT, 4: bits processed per cycle. NDIG = WIDTH/DIGIT; NDIG = 1 is legal.
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset, asynchronous, active-high.
- Start  in  1  request; sampled only in IDLE or DONE.
- Sub  in  1  0: S = A + B + CIn. 1: S = A − B − CIn, where CIn is the borrow-in.
- CIn  in  1  carry-in (Sub=0) or borrow-in (Sub=1).
- A, B  in  WIDTH  operands; captured on the accepted Start edge.
- Busy  out  1  high while digits are being processed.
- Done  out  1  one-cycle pulse; S/COut/Ovf are updated in the same cycle.
- S  out  WIDTH  result; held until the next Done.
- COut  out  1  raw carry out of the MSB. For Sub=1, COut=1 means no borrow.
- Ovf  out  1  two's-complement overflow of the full-width operation.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on Start.
  - RUN → DONE when digit counter = NDIG−1; otherwise stay in RUN and increment the counter.
  - DONE → RUN on Start; DONE → IDLE otherwise.
- On the accepted Start edge:
  - Register A.
  - Register Bx = Sub ? ~B : B.
  - carry = Sub ? ~CIn : CIn.
  - Clear the digit counter.
- Each RUN cycle, digit i (LSB digit first):
  - {c, s} = A_i + Bx_i + carry.
  - carry ← c.
  - s is shifted into the internal result register from the MSB side.
- Last digit:
  - Ovf = (A[WIDTH−1] == Bx[WIDTH−1]) && (s_msb != A[WIDTH−1]).
  - S, COut and Ovf are loaded into the output registers on the same edge that enters DONE.
- Start in RUN is ignored. A, B, Sub and CIn changing after acceptance have no effect.
- Start held high continuously: operations run back-to-back, with a period of NDIG+1 cycles.
- All arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Reset values: Busy=0, Done=0, S=0, COut=0, Ovf=0; state IDLE; internal counter, carry and operand registers cleared.
- Reset asserted mid-RUN or in DONE aborts the operation immediately (asynchronous). Outputs go to their reset values without waiting for an edge.
- Start sampled high at edge t0 (state IDLE):
  - Busy=1 from t0 until edge t0+NDIG.
  - Done=1, Busy=0 for exactly one cycle after edge t0+NDIG.
  - Latency, Start edge to valid result: NDIG cycles.
- Done and Busy are never high together.
- Start sampled at edge t0+NDIG+1 (state DONE) begins the next operation. Busy rises after that edge.
- NDIG=1: a single RUN cycle, so Done follows the edge after Start.
- Counter width: max(1, $clog2(NDIG)).

## Structure
- Shared package `adder_pkg`:
  - state typedef {IDLE, RUN, DONE}.
  - function computing NDIG and the counter width.
- Sub-module `fa_n #(N)`: N-bit combinational ripple-carry adder chaining 1-bit full-adder cells; ports A, B, CIn, S, COut.
  - Instantiated once, with N=DIGIT.
  - Ovf logic stays in the parent.
- Elaboration-time check: WIDTH % DIGIT == 0 and DIGIT ≥ 1; otherwise `$error`.

## Test plan
Default configuration WIDTH=16, DIGIT=4 unless noted.
- Add after reset: A=0x1234, B=0x4321, CIn=0, Sub=0, one-cycle Start → Busy for 4 cycles, then Done pulse; S=0x5555, COut=0, Ovf=0.
- Unsigned wrap: A=0xFFFF, B=0x0001, CIn=0, Sub=0 → S=0x0000, COut=1, Ovf=0. Signed overflow: A=0x7FFF, B=0x0001 → S=0x8000, COut=0, Ovf=1.
- Subtract: A=0x8000, B=0x0001, Sub=1, CIn=0 → S=0x7FFF, COut=1, Ovf=1. Borrow case: A=0x0003, B=0x0005, Sub=1, CIn=1 → S=0xFFFD, COut=0, Ovf=0.
- Handshake:
  - Start pulsed and A/B changed during Busy → result unchanged, no extra Done.
  - Start held high for 3 operations → Done every 5 cycles; S holds between pulses.
- Reset mid-RUN (after digit 2) → Busy=0 and S=0 immediately, no Done. A subsequent Start completes normally.
- Config WIDTH=4, DIGIT=4: A=4, B=5, CIn=0, Sub=0 → Done one cycle after Start; S=0x9, COut=0, Ovf=1.
